sp_rom_fetch: RTL and testbench

//  Synchronous burst-read controller for the 120 ns async sprite (SP) ROM, 128k x 16.

---
 rtl/sp_rom_fetch.sv | 69 ++++++
 tb/tb_sp_rom_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_rom_fetch.sv
`timescale 1ns/1ps
// sp_rom_fetch: burst-read controller for the 120 ns async sprite ROM, packs BURST words into one line
module sp_rom_fetch #(
  parameter int ADDR_W   = 17,
  parameter int BURST    = 4,
  parameter int WAIT_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 rom_noe,
  input  logic [15:0]          rom_data,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [16*BURST-1:0]  line_data,
  output logic                 busy
);
  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam int IW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  // each address is held WAIT_CYC clocks so the slow ROM settles before its word is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      rom_noe    <= 1'b1;
      line_valid <= 1'b0;
      line_data  <= '0;
      cnt        <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rom_addr <= req_addr;
          rom_noe  <= 1'b0;
          cnt      <= '0;
          idx      <= '0;
          state    <= FETCH;
        end
        FETCH: if (cnt != CW'(WAIT_CYC - 1)) cnt <= cnt + 1'b1;
        else begin
          line_data[16*idx +: 16] <= rom_data;
          cnt <= '0;
          if (idx != IW'(BURST - 1)) begin
            idx      <= idx + 1'b1;
            rom_addr <= rom_addr + 1'b1;
          end else begin
            rom_noe    <= 1'b1;
            line_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: if (line_ready) begin
          line_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_rom_fetch.sv
`timescale 1ns/1ps
// tb_sp_rom_fetch: scoreboard bench with a 120 ns async ROM model, default build plus a BURST=2/WAIT_CYC=3 build
module tb_sp_rom_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, line_ready = 1'b1;
  logic [16:0] req_addr = '0;
  logic        req_ready, rom_noe, line_valid, busy;
  logic [16:0] rom_addr;
  logic [15:0] rom_data = 16'hxxxx;
  logic [63:0] line_data;
  logic        r6_valid = 1'b0, r6_ready, n6, l6_valid, b6;
  logic [16:0] r6_addr = '0, a6;
  logic [15:0] d6 = 16'hxxxx;
  logic [31:0] l6_data;
  int          tests = 0, fails = 0, cyc = 0;

  always #20.833 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_rom_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rom_addr(rom_addr), .rom_noe(rom_noe), .rom_data(rom_data), .line_valid(line_valid),
    .line_ready(line_ready), .line_data(line_data), .busy(busy));

  sp_rom_fetch #(.ADDR_W(17), .BURST(2), .WAIT_CYC(3)) u_b2 (
    .clk(clk), .rst_n(rst_n), .req_valid(r6_valid), .req_ready(r6_ready), .req_addr(r6_addr),
    .rom_addr(a6), .rom_noe(n6), .rom_data(d6), .line_valid(l6_valid),
    .line_ready(1'b1), .line_data(l6_data), .busy(b6));

  real t_chg = 0.0, t6 = 0.0;
  always @(rom_addr or rom_noe) t_chg = $realtime;
  always @(a6 or n6) t6 = $realtime;
  always #1 rom_data = (!rom_noe && $realtime - t_chg >= 120.0) ? rom_addr[15:0] ^ 16'hA5A5 : 16'hxxxx;
  always #1 d6 = (!n6 && $realtime - t6 >= 120.0) ? a6[15:0] ^ 16'hA5A5 : 16'hxxxx;

  typedef struct { logic [63:0] d; int due; } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic lv_prev;
    int   noe_n;
    exp_t e;
    lv_prev = 1'b0;
    noe_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lv_prev = 1'b0;
        noe_n = 0;
      end else begin
        if (!rom_noe) noe_n++;
        if (!rom_noe || line_valid) chk("ready_while_busy", req_ready, 0);
        if (line_valid && !lv_prev) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_line: got %h expected none", line_data);
          end else begin
            e = q.pop_front();
            chk("line_data", line_data, e.d);
            chk("latency", cyc, e.due);
            chk("noe_clocks", noe_n, 16);
          end
          noe_n = 0;
        end
        lv_prev = line_valid;
      end
    end
  end

  task automatic req(input logic [16:0] a, input logic [63:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_timeout", n, 0);
    q.push_back('{d, cyc + 17});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_lv();
    int n;
    n = 0;
    while (!line_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("line_valid_timeout", n, 0);
  endtask

  initial begin
    logic [63:0] held;
    int acc, prev, n;
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_noe", rom_noe, 1);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_b2_data", l6_data, 0);
    rst_n = 1'b1;
    // basic burst
    req(17'h00010, 64'hA5B6_A5B7_A5B4_A5B5);
    repeat (20) @(negedge clk);
    // consumer back-pressure
    line_ready = 1'b0;
    req(17'h00010, 64'hA5B6_A5B7_A5B4_A5B5);
    wait_lv();
    held = line_data;
    repeat (20) @(negedge clk);
    chk("hold_data", line_data, held);
    chk("hold_rom_addr", rom_addr, 17'h00013);
    chk("hold_noe", rom_noe, 1);
    chk("hold_valid", line_valid, 1);
    chk("hold_req_ready", req_ready, 0);
    line_ready = 1'b1;
    @(posedge clk);
    #1 chk("release_valid", line_valid, 0);
    chk("release_req_ready", req_ready, 1);
    // address wrap
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 17'h1FFFE;
    q.push_back('{64'hA5A4_A5A5_5A5A_5A5B, cyc + 17});
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wrap_addr0", rom_addr, 17'h1FFFE);
    repeat (4) @(posedge clk);
    #1 chk("wrap_addr1", rom_addr, 17'h1FFFF);
    repeat (4) @(posedge clk);
    #1 chk("wrap_addr2", rom_addr, 17'h00000);
    repeat (4) @(posedge clk);
    #1 chk("wrap_addr3", rom_addr, 17'h00001);
    repeat (10) @(negedge clk);
    // abort by reset mid-fetch
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 17'h00040;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #5 rst_n = 1'b0;
    #1 chk("abort_noe", rom_noe, 1);
    chk("abort_valid", line_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    req(17'h00100, 64'hA4A6_A4A7_A4A4_A4A5);
    repeat (20) @(negedge clk);
    // back-to-back with VALID held high
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 17'h00010;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) chk("b2b_timeout", n, 0);
      acc = cyc + 1;
      q.push_back('{64'hA5B6_A5B7_A5B4_A5B5, acc + 16});
      if (k > 0) chk("b2b_period", acc - prev, 18);
      prev = acc;
      @(posedge clk);
      #1 if (k == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    // BURST=2, WAIT_CYC=3 build
    @(negedge clk);
    r6_valid = 1'b1;
    r6_addr = 17'h00020;
    acc = cyc + 1;
    @(posedge clk);
    #1 r6_valid = 1'b0;
    n = 0;
    while (!l6_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2_latency", cyc, acc + 6);
    chk("b2_data", l6_data, 32'hA584_A585);
    chk("b2_width", $bits(l6_data), 32);
    repeat (5) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
